// File: rtl/note_sequencer.sv
// note_sequencer: steps through a table of (stepsize, gain, duration) entries
// and drives a frequency generator. Durations are counted in prescaled ticks;
// an optional silent gap follows each note. Table contents survive reset.
module note_sequencer #(
  parameter int NOTES     = 16,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     wr_en,
  input  logic [$clog2(NOTES)-1:0] wr_addr,
  input  logic [15:0]              wr_stepsize,
  input  logic [4:0]               wr_gain,
  input  logic [11:0]              wr_duration,
  output logic [15:0]              stepsize,
  output logic [4:0]               gain,
  output logic [$clog2(NOTES)-1:0] note_index,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = $clog2(NOTES);
  localparam int PW = $clog2(TICK_DIV);
  // Remaining counter also holds the gap length, so widen it if needed.
  localparam int RW = ($clog2(GAP_TICKS + 1) > 12) ? $clog2(GAP_TICKS + 1) : 12;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ZERO = PW'(1'b0);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1'b1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NOTES - 1);
  localparam logic [IW-1:0] IDX_ZERO = IW'(1'b0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1'b1);
  localparam logic [RW-1:0] REM_ZERO = RW'(1'b0);
  localparam logic [RW-1:0] REM_ONE  = RW'(1'b1);
  localparam logic [RW-1:0] GAP_LOAD = RW'(GAP_TICKS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Table storage: {stepsize, gain, duration}
  logic [32:0]   table_mem [NOTES];
  logic [32:0]   rd_data_r;
  logic          rd_en_s;
  logic [15:0]   rd_step_s;
  logic [4:0]    rd_gain_s;
  logic [11:0]   rd_dur_s;

  state_t        state_r;
  state_t        state_nx_s;
  logic          load_ph_r;
  logic          ph_nx_s;
  logic [PW-1:0] pre_r;
  logic [PW-1:0] pre_nx_s;
  logic [RW-1:0] rem_r;
  logic [RW-1:0] rem_nx_s;
  logic [IW-1:0] idx_nx_s;
  logic          tick_s;

  state_t        eot_state_s;
  logic [IW-1:0] eot_idx_s;
  state_t        adv_state_s;
  logic [IW-1:0] adv_idx_s;

  logic [15:0]   step_nx_s;
  logic [4:0]    gain_nx_s;
  logic          busy_nx_s;
  logic          done_nx_s;

  // The read is issued only in the first LOAD cycle; data is used in the second.
  assign rd_en_s   = (state_r == ST_LOAD) && !load_ph_r;
  assign rd_step_s = rd_data_r[32:17];
  assign rd_gain_s = rd_data_r[16:12];
  assign rd_dur_s  = rd_data_r[11:0];
  assign tick_s    = (pre_r == PRE_LAST);

  // End of table: loop back to entry 0 unless already at entry 0 (avoids a
  // spin on an empty table); otherwise finish, keeping the index for DONE.
  assign eot_state_s = (loop && (note_index != IDX_ZERO)) ? ST_LOAD : ST_DONE;
  assign eot_idx_s   = (loop && (note_index != IDX_ZERO)) ? IDX_ZERO : note_index;
  assign adv_state_s = (note_index == IDX_LAST) ? eot_state_s : ST_LOAD;
  assign adv_idx_s   = (note_index == IDX_LAST) ? eot_idx_s : (note_index + IDX_ONE);

  // Note table RAM: read-before-write, so a same-address collision returns old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_mem[wr_addr] <= {wr_stepsize, wr_gain, wr_duration};
    end
    if (rd_en_s) begin
      rd_data_r <= table_mem[note_index];
    end
  end

  // State and registered outputs; reset clears everything except the table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      load_ph_r  <= 1'b0;
      pre_r      <= PRE_ZERO;
      rem_r      <= REM_ZERO;
      note_index <= IDX_ZERO;
      stepsize   <= 16'h0000;
      gain       <= 5'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      load_ph_r  <= ph_nx_s;
      pre_r      <= pre_nx_s;
      rem_r      <= rem_nx_s;
      note_index <= idx_nx_s;
      stepsize   <= step_nx_s;
      gain       <= gain_nx_s;
      busy       <= busy_nx_s;
      done       <= done_nx_s;
    end
  end

  // Next-state logic: sequencing, prescaler and remaining-tick counter.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = note_index;
    ph_nx_s    = load_ph_r;
    pre_nx_s   = pre_r;
    rem_nx_s   = rem_r;
    if (stop) begin
      state_nx_s = ST_IDLE;
      idx_nx_s   = IDX_ZERO;
      ph_nx_s    = 1'b0;
      pre_nx_s   = PRE_ZERO;
      rem_nx_s   = REM_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nx_s = ST_LOAD;
            idx_nx_s   = IDX_ZERO;
            ph_nx_s    = 1'b0;
            pre_nx_s   = PRE_ZERO;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          pre_nx_s = PRE_ZERO;
          if (!load_ph_r) begin
            ph_nx_s = 1'b1;
          end else begin
            ph_nx_s = 1'b0;
            if (rd_dur_s != 12'd0) begin
              state_nx_s = ST_PLAY;
              rem_nx_s   = RW'(rd_dur_s);
            end else begin
              state_nx_s = eot_state_s;
              idx_nx_s   = eot_idx_s;
            end
          end
        end
        ST_PLAY, ST_GAP: begin
          if (tick_s) begin
            pre_nx_s = PRE_ZERO;
            if (rem_r == REM_ONE) begin
              if ((state_r == ST_PLAY) && (GAP_TICKS > 0)) begin
                state_nx_s = ST_GAP;
                rem_nx_s   = GAP_LOAD;
              end else begin
                state_nx_s = adv_state_s;
                idx_nx_s   = adv_idx_s;
                rem_nx_s   = REM_ZERO;
              end
            end else begin
              rem_nx_s = rem_r - REM_ONE;
            end
          end else begin
            pre_nx_s = pre_r + PRE_ONE;
          end
        end
        ST_DONE: begin
          state_nx_s = ST_IDLE;
          idx_nx_s   = IDX_ZERO;
          pre_nx_s   = PRE_ZERO;
        end
        default: begin
          state_nx_s = ST_IDLE;
          idx_nx_s   = IDX_ZERO;
          ph_nx_s    = 1'b0;
          pre_nx_s   = PRE_ZERO;
          rem_nx_s   = REM_ZERO;
        end
      endcase
    end
  end

  // Output values for the next cycle, derived from the state being entered.
  always_comb begin
    step_nx_s = stepsize;
    gain_nx_s = gain;
    case (state_nx_s)
      ST_IDLE, ST_DONE: begin
        step_nx_s = 16'h0000;
        gain_nx_s = 5'd0;
      end
      ST_LOAD: begin
        step_nx_s = stepsize;
        gain_nx_s = gain;
      end
      ST_PLAY: begin
        if (state_r == ST_LOAD) begin
          step_nx_s = rd_step_s;
          gain_nx_s = rd_gain_s;
        end else begin
          step_nx_s = stepsize;
          gain_nx_s = gain;
        end
      end
      ST_GAP: begin
        step_nx_s = 16'h0000;
        gain_nx_s = gain;
      end
      default: begin
        step_nx_s = 16'h0000;
        gain_nx_s = 5'd0;
      end
    endcase
    busy_nx_s = (state_nx_s != ST_IDLE);
    done_nx_s = (state_nx_s == ST_DONE);
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench. Stimulus pushes expected output
// segments (output tuple + run length in cycles); a monitor run-length
// encodes each DUT's outputs and pops/compares every non-idle segment.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset, start0, start1, stop, loop, wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_stepsize;
  logic [4:0]  wr_gain;
  logic [11:0] wr_duration;
  logic [15:0] step0, step1;
  logic [4:0]  gain0, gain1;
  logic [1:0]  idx0, idx1;
  logic        busy0, busy1, done0, done1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [15:0] step;
    logic [4:0]  gain;
    logic [1:0]  idx;
  } tup_t;

  typedef struct packed {
    tup_t        t;
    logic [15:0] len;
  } seg_t;

  seg_t exp_q[$];

  always #5 clk = ~clk;

  note_sequencer #(.NOTES(4), .TICK_DIV(4), .GAP_TICKS(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_stepsize(wr_stepsize),
    .wr_gain(wr_gain), .wr_duration(wr_duration),
    .stepsize(step0), .gain(gain0), .note_index(idx0), .busy(busy0), .done(done0)
  );

  note_sequencer #(.NOTES(4), .TICK_DIV(4), .GAP_TICKS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_stepsize(wr_stepsize),
    .wr_gain(wr_gain), .wr_duration(wr_duration),
    .stepsize(step1), .gain(gain1), .note_index(idx1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_seg(input int ch, input tup_t t, input int len);
    seg_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL seg dut%0d: unexpected busy=%0b done=%0b step=%h gain=%0d idx=%0d len=%0d",
               ch, t.busy, t.done, t.step, t.gain, t.idx, len);
    end else begin
      e = exp_q.pop_front();
      if ((e.t !== t) || (e.len !== 16'(len))) begin
        errors++;
        $display("FAIL seg dut%0d: got busy=%0b done=%0b step=%h gain=%0d idx=%0d len=%0d, want busy=%0b done=%0b step=%h gain=%0d idx=%0d len=%0d",
                 ch, t.busy, t.done, t.step, t.gain, t.idx, len,
                 e.t.busy, e.t.done, e.t.step, e.t.gain, e.t.idx, e.len);
      end
    end
  endtask

  task automatic exp_seg(input logic b, input logic d, input logic [15:0] s,
                         input logic [4:0] g, input logic [1:0] i, input int len);
    seg_t e;
    e.t.busy = b;
    e.t.done = d;
    e.t.step = s;
    e.t.gain = g;
    e.t.idx  = i;
    e.len    = 16'(len);
    exp_q.push_back(e);
  endtask

  // busy segment (LOAD/PLAY/GAP)
  task automatic ep(input logic [15:0] s, input logic [4:0] g, input logic [1:0] i, input int len);
    exp_seg(1'b1, 1'b0, s, g, i, len);
  endtask

  // DONE pulse: one cycle, outputs zero, index held
  task automatic ed(input logic [1:0] i);
    exp_seg(1'b1, 1'b1, 16'h0000, 5'd0, i, 1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] s, input logic [4:0] g, input logic [11:0] d);
    @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = a; wr_stepsize = s; wr_gain = g; wr_duration = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Returns 1 ns after the edge that samples start.
  task automatic pulse_start(input int ch);
    @(posedge clk);
    #1;
    if (ch == 0) start0 = 1'b1;
    else         start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (((exp_q.size() != 0) || busy0 || busy1) && (n < 300)) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s: timeout, %0d segments pending, want 0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: run-length encode each DUT's outputs, compare closed non-idle segments.
  initial begin
    tup_t prev [2];
    tup_t cur  [2];
    int   run  [2];
    prev[0] = '0; prev[1] = '0;
    run[0]  = 0;  run[1]  = 0;
    forever begin
      @(negedge clk);
      cur[0] = {busy0, done0, step0, gain0, idx0};
      cur[1] = {busy1, done1, step1, gain1, idx1};
      for (int i = 0; i < 2; i++) begin
        if (cur[i] !== prev[i]) begin
          if (prev[i] !== '0) check_seg(i, prev[i], run[i]);
          prev[i] = cur[i];
          run[i]  = 1;
        end else begin
          run[i] = run[i] + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    reset = 1'b0; start0 = 1'b0; start1 = 1'b0; stop = 1'b0; loop = 1'b0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_stepsize = 16'h0000; wr_gain = 5'd0; wr_duration = 12'd0;
    #1 reset = 1'b1;
    #2;
    check("reset outs dut0", 32'({busy0, done0, step0, gain0, idx0}), 32'd0);
    check("reset outs dut1", 32'({busy1, done1, step1, gain1, idx1}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Basic playback, loop=0; entry 1 rewritten in the cycle it is read (old data wins).
    wr(2'd0, 16'h1000, 5'd3, 12'd2);
    wr(2'd1, 16'h2000, 5'd0, 12'd1);
    wr(2'd2, 16'h0000, 5'd0, 12'd0);
    wr(2'd3, 16'h7777, 5'd9, 12'd5);
    loop = 1'b0;
    ep(16'h0000, 5'd0, 2'd0, 2);
    ep(16'h1000, 5'd3, 2'd0, 8);
    ep(16'h1000, 5'd3, 2'd1, 2);
    ep(16'h2000, 5'd0, 2'd1, 4);
    ep(16'h2000, 5'd0, 2'd2, 2);
    ed(2'd2);
    pulse_start(0);
    repeat (10) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = 2'd1; wr_stepsize = 16'h3000; wr_gain = 5'd6; wr_duration = 12'd1;
    @(posedge clk);
    #1 wr_en = 1'b0;
    wait_idle("basic");

    // Loop=1 repeats the table (with updated entry 1); stop mid second pass.
    loop = 1'b1;
    ep(16'h0000, 5'd0, 2'd0, 2);
    ep(16'h1000, 5'd3, 2'd0, 8);
    ep(16'h1000, 5'd3, 2'd1, 2);
    ep(16'h3000, 5'd6, 2'd1, 4);
    ep(16'h3000, 5'd6, 2'd2, 2);
    ep(16'h3000, 5'd6, 2'd0, 2);
    ep(16'h1000, 5'd3, 2'd0, 8);
    ep(16'h1000, 5'd3, 2'd1, 2);
    ep(16'h3000, 5'd6, 2'd1, 2);
    pulse_start(0);
    repeat (31) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    check("stop busy", 32'(busy0), 32'd0);
    check("stop stepsize", 32'(step0), 32'd0);
    loop = 1'b0;
    wait_idle("loop stop");

    // Entry 0 is an end marker with loop=1: must finish, not spin.
    wr(2'd0, 16'h1234, 5'd7, 12'd0);
    loop = 1'b1;
    ep(16'h0000, 5'd0, 2'd0, 2);
    ed(2'd0);
    pulse_start(0);
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done0) found = 1'b1;
      @(posedge clk);
      #1;
    end
    check("empty table done", 32'(found), 32'd1);
    loop = 1'b0;
    wait_idle("empty table");

    // All entries duration 1: wrap after last index, loop=0 then loop=1.
    wr(2'd0, 16'h0100, 5'd1, 12'd1);
    wr(2'd1, 16'h0200, 5'd2, 12'd1);
    wr(2'd2, 16'h0300, 5'd4, 12'd1);
    wr(2'd3, 16'h0400, 5'd8, 12'd1);
    ep(16'h0000, 5'd0, 2'd0, 2);
    ep(16'h0100, 5'd1, 2'd0, 4);
    ep(16'h0100, 5'd1, 2'd1, 2);
    ep(16'h0200, 5'd2, 2'd1, 4);
    ep(16'h0200, 5'd2, 2'd2, 2);
    ep(16'h0300, 5'd4, 2'd2, 4);
    ep(16'h0300, 5'd4, 2'd3, 2);
    ep(16'h0400, 5'd8, 2'd3, 4);
    ed(2'd3);
    pulse_start(0);
    wait_idle("full table once");

    loop = 1'b1;
    ep(16'h0000, 5'd0, 2'd0, 2);
    ep(16'h0100, 5'd1, 2'd0, 4);
    ep(16'h0100, 5'd1, 2'd1, 2);
    ep(16'h0200, 5'd2, 2'd1, 4);
    ep(16'h0200, 5'd2, 2'd2, 2);
    ep(16'h0300, 5'd4, 2'd2, 4);
    ep(16'h0300, 5'd4, 2'd3, 2);
    ep(16'h0400, 5'd8, 2'd3, 4);
    ep(16'h0400, 5'd8, 2'd0, 2);
    ep(16'h0100, 5'd1, 2'd0, 4);
    pulse_start(0);
    repeat (29) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    loop = 1'b0;
    wait_idle("full table loop");

    // Gap of one tick (dut1): stepsize 0 with gain held between notes.
    wr(2'd0, 16'h1000, 5'd3, 12'd2);
    wr(2'd1, 16'h2000, 5'd5, 12'd1);
    wr(2'd2, 16'h0000, 5'd0, 12'd0);
    ep(16'h0000, 5'd0, 2'd0, 2);
    ep(16'h1000, 5'd3, 2'd0, 8);
    ep(16'h0000, 5'd3, 2'd0, 4);
    ep(16'h0000, 5'd3, 2'd1, 2);
    ep(16'h2000, 5'd5, 2'd1, 4);
    ep(16'h0000, 5'd5, 2'd1, 4);
    ep(16'h0000, 5'd5, 2'd2, 2);
    ed(2'd2);
    pulse_start(1);
    wait_idle("gap");

    // Asynchronous reset mid-PLAY, then a fresh start plays from entry 0.
    ep(16'h0000, 5'd0, 2'd0, 2);
    ep(16'h1000, 5'd3, 2'd0, 2);
    pulse_start(0);
    repeat (4) @(posedge clk);
    #1;
    check("playing before reset", 32'(step0), 32'h1000);
    #1 reset = 1'b1;
    #1;
    check("async reset outs", 32'({busy0, done0, step0, gain0, idx0}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    ep(16'h0000, 5'd0, 2'd0, 2);
    ep(16'h1000, 5'd3, 2'd0, 8);
    ep(16'h1000, 5'd3, 2'd1, 2);
    ep(16'h2000, 5'd5, 2'd1, 4);
    ep(16'h2000, 5'd5, 2'd2, 2);
    ed(2'd2);
    pulse_start(0);
    wait_idle("after reset");

    // start and stop together from IDLE: stop wins.
    @(posedge clk);
    #1;
    start0 = 1'b1;
    stop   = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    stop   = 1'b0;
    check("start+stop busy", 32'(busy0), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("start+stop busy later", 32'(busy0), 32'd0);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter NOTES, default 16: note table depth; power of two, 2..256.
REQ-002 Parameter TICK_DIV, default 50000: clk cycles per duration tick (1 ms at 50 MHz); >=2.
REQ-003 Parameter GAP_TICKS, default 0: silent ticks inserted after each note; 0 = no gap.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin playback at entry 0.
REQ-007 stop  in  1  abort playback.
REQ-008 loop  in  1  1 = restart at entry 0 at end of table; sampled at each end-of-table event.
REQ-009 wr_en  in  1  note table write strobe.
REQ-010 wr_addr  in  clog2(NOTES)  table write index.
REQ-011 wr_stepsize  in  16  phase step for the entry, frequency-generator units.
REQ-012 wr_gain  in  5  gain code for the entry, frequency-generator encoding.
REQ-013 wr_duration  in  12  note length in ticks; 0 = end-of-table marker.
REQ-014 stepsize  out  16  registered; drives the generator's stepsize input.
REQ-015 gain  out  5  registered; drives the generator's gain input.
REQ-016 note_index  out  clog2(NOTES)  entry currently loaded or playing.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse on natural end of playback.

Function
REQ-019 States SHALL be IDLE, LOAD, PLAY, GAP, DONE.
REQ-020 Table SHALL be synchronous RAM, one write port, one read port; the read issued in LOAD returns data on the next cycle.
REQ-021 A write and a read to the same address in the same cycle SHALL return the old data.
REQ-022 Writes SHALL be accepted in all states and take effect only when that entry is next loaded.
REQ-023 IDLE: stepsize=0, gain=0; start -> LOAD with note_index=0.
REQ-024 start SHALL be ignored when busy=1.
REQ-025 LOAD lasts 2 cycles (read issue, data capture); the prescaler is held at 0.
REQ-026 LOAD with duration!=0 -> PLAY; stepsize, gain and the remaining counter (=duration) SHALL update in the same cycle PLAY is entered.
REQ-027 LOAD with duration=0 (end marker) -> if loop=1 and note_index!=0 -> LOAD at index 0; otherwise -> DONE.
REQ-028 Prescaler SHALL count 0..TICK_DIV-1 in PLAY and GAP; the tick strobe SHALL assert when the count = TICK_DIV-1; the count SHALL wrap to 0.
REQ-029 PLAY: each tick decrements remaining; the tick with remaining=1 SHALL end the note.
REQ-030 Note end: if GAP_TICKS>0 -> GAP with stepsize=0 and gain held, for GAP_TICKS ticks; else advance directly.
REQ-031 Advance: if note_index=NOTES-1, treat as end marker per REQ-027; else LOAD with note_index+1.
REQ-032 DONE SHALL last 1 cycle, with done=1, stepsize=0, gain=0 -> IDLE.
REQ-033 stop in any state SHALL force IDLE on the next edge, with stepsize=0, gain=0, note_index=0 and no done pulse.
REQ-034 stop SHALL win when asserted together with start.
REQ-035 Note playback length SHALL be exactly duration*TICK_DIV cycles of stepsize held.

Reset
REQ-036 On reset assertion, immediately: state=IDLE, stepsize=0, gain=0, note_index=0, busy=0, done=0, prescaler=0, remaining=0.
REQ-037 Table contents SHALL NOT be reset.
REQ-038 Reset mid-playback SHALL abort with no done pulse; the first start after release plays from entry 0.

Verification (TICK_DIV=4, NOTES=4, GAP_TICKS=0 unless stated)
REQ-039 Setup: table {(0x1000,3,2),(0x2000,0,1),(x,x,0)}, loop=0, start -> stepsize=0x1000/gain=3 for 8 cycles, then 2 LOAD cycles, then 0x2000/gain=0 for 4 cycles; done pulse 1 cycle after the marker load; busy falls one cycle later.
REQ-040 Same table, loop=1 -> the sequence repeats 0x1000, 0x2000, 0x1000...; done is never pulsed; stop -> next edge stepsize=0, busy=0.
REQ-041 Entry 0 duration=0, loop=1, start -> DONE with no lockup; done pulses within 4 cycles of start.
REQ-042 GAP_TICKS=1 -> stepsize=0 for 4 cycles between notes, with gain held at the prior value.
REQ-043 All 4 entries duration=1 -> after index 3, wrap handling per REQ-031 (done if loop=0; index 0 if loop=1).
REQ-044 Reset pulse mid-PLAY -> outputs 0 asynchronously (before the next clk edge); start plus stop in the same cycle from IDLE -> busy stays 0.
